icache_set_assoc: RTL and testbench

ICACHE_SET_ASSOC -- requirements
Module: icache_set_assoc

---
 rtl/icache_set_assoc.sv | 188 ++++++++++++++++++
 tb/tb_icache_set_assoc.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_set_assoc.sv
// 2-way set-associative instruction cache with LRU replacement and
// multi-beat line refill. Optional invalidate-all port via ICACHE_FLUSH_EN.
module icache_set_assoc #(
   parameter int unsigned INDEX_BITS  = 4,
   parameter int unsigned OFFSET_BITS = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
`ifdef ICACHE_FLUSH_EN
   input  logic        flush,
`endif
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_valid,
   input  logic [31:0] mem_data
);

   localparam int unsigned SETS     = 1 << INDEX_BITS;
   localparam int unsigned WORDS    = 1 << OFFSET_BITS;
   localparam int unsigned TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;
   localparam int unsigned TAG_BITS = 32 - TAG_LSB;
   localparam logic [OFFSET_BITS-1:0] LAST_BEAT = '1;

   typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

   state_t state, state_next;

   logic [TAG_BITS-1:0]    tag_arr  [2][SETS];
   logic [31:0]            data_arr [2][SETS][WORDS];
   logic [SETS-1:0]        valid    [2];
   logic [SETS-1:0]        lru;
   logic [31:0]            line_buf [WORDS];

   logic [TAG_BITS-1:0]    req_tag;
   logic [INDEX_BITS-1:0]  req_idx;
   logic [OFFSET_BITS-1:0] req_off;
   logic [OFFSET_BITS-1:0] cnt, cnt_inc;

   logic [TAG_BITS-1:0]    in_tag;
   logic [INDEX_BITS-1:0]  in_idx;
   logic [OFFSET_BITS-1:0] in_off;
   logic                   hit0, hit1, hit, hit_way, miss, fill_done, victim;
   logic [31:0]            hit_word;
   logic                   flush_now;
   logic                   unused_addr_bits;

`ifdef ICACHE_FLUSH_EN
   assign flush_now = flush;
`else
   assign flush_now = 1'b0;
`endif

   assign in_tag  = req_addr[31:TAG_LSB];
   assign in_idx  = req_addr[TAG_LSB-1:OFFSET_BITS+2];
   assign in_off  = req_addr[OFFSET_BITS+1:2];
   assign cnt_inc = cnt + 1'b1;
   assign unused_addr_bits = ^req_addr[1:0];

   assign hit0     = valid[0][in_idx] && (tag_arr[0][in_idx] == in_tag);
   assign hit1     = valid[1][in_idx] && (tag_arr[1][in_idx] == in_tag);
   assign hit_word = hit0 ? data_arr[0][in_idx][in_off] : data_arr[1][in_idx][in_off];

   assign req_ready = (state == IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else if (rdy)
         state <= state_next;
   end

   // Next-state decode and per-cycle control strobes; flush overrides everything
   always_comb begin
      state_next = state;
      hit        = 1'b0;
      hit_way    = 1'b0;
      miss       = 1'b0;
      fill_done  = 1'b0;
      if (!valid[0][req_idx])
         victim = 1'b0;
      else if (!valid[1][req_idx])
         victim = 1'b1;
      else
         victim = lru[req_idx];
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (hit0 || hit1) begin
                  hit     = 1'b1;
                  hit_way = !hit0;
               end else begin
                  miss       = 1'b1;
                  state_next = REFILL;
               end
            end
         end
         REFILL: begin
            if (mem_valid && (cnt == LAST_BEAT)) begin
               fill_done  = 1'b1;
               state_next = RESPOND;
            end
         end
         RESPOND: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush_now) begin
         state_next = IDLE;
         hit        = 1'b0;
         miss       = 1'b0;
         fill_done  = 1'b0;
      end
   end

   // Valid/LRU bookkeeping, beat counter and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid[0]   <= '0;
         valid[1]   <= '0;
         lru        <= '0;
         cnt        <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
      end else if (rdy) begin
         resp_valid <= 1'b0;
         if (flush_now) begin
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
            cnt      <= '0;
            mem_req  <= 1'b0;
         end else begin
            if (hit) begin
               resp_valid  <= 1'b1;
               resp_data   <= hit_word;
               lru[in_idx] <= !hit_way;
            end
            if (miss) begin
               cnt      <= '0;
               mem_req  <= 1'b1;
               mem_addr <= {in_tag, in_idx, {OFFSET_BITS{1'b0}}, 2'b00};
            end
            if (state == REFILL && mem_valid) begin
               cnt      <= cnt_inc;
               mem_addr <= {req_tag, req_idx, cnt_inc, 2'b00};
            end
            if (fill_done) begin
               mem_req                <= 1'b0;
               valid[victim][req_idx] <= 1'b1;
               lru[req_idx]           <= !victim;
            end
            if (state == RESPOND) begin
               resp_valid <= 1'b1;
               resp_data  <= line_buf[req_off];
            end
         end
      end
   end

   // Request latch, line buffer and tag/data array writes (no reset needed)
   always_ff @(posedge clk) begin
      if (rst_n && rdy) begin
         if (miss) begin
            req_tag <= in_tag;
            req_idx <= in_idx;
            req_off <= in_off;
         end
         if (state == REFILL && mem_valid)
            line_buf[cnt] <= mem_data;
         // The final beat bypasses the line buffer so the whole line lands in one write
         if (fill_done) begin
            tag_arr[victim][req_idx] <= req_tag;
            for (int unsigned w = 0; w < WORDS; w++)
               data_arr[victim][req_idx][OFFSET_BITS'(w)] <=
                  (w == WORDS - 1) ? mem_data : line_buf[OFFSET_BITS'(w)];
         end
      end
   end

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed self-checking bench for icache_set_assoc (default parameters).
module tb_icache_set_assoc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdy = 1'b1;
`ifdef ICACHE_FLUSH_EN
   logic        flush = 1'b0;
`endif
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_data = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   icache_set_assoc #(.INDEX_BITS(4), .OFFSET_BITS(2)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy),
`ifdef ICACHE_FLUSH_EN
      .flush(flush),
`endif
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_valid(mem_valid), .mem_data(mem_data)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Full miss: request, four beats with address checks, response two cycles later
   task automatic do_miss(input logic [31:0] addr, input logic [31:0] base, input string name);
      logic [31:0] line_addr;
      logic [31:0] exp_word;
      line_addr = addr & 32'hFFFF_FFF0;
      exp_word  = base + {30'd0, addr[3:2]};
      req_valid = 1'b1; req_addr = addr;
      tick;
      req_valid = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s miss_start: mem_req=%b req_ready=%b required 1/0", name, mem_req, req_ready);
      end
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (mem_addr !== line_addr + 32'(4 * b)) begin
            errors++;
            $display("FAIL %s beat%0d_addr: got %h required %h", name, b, mem_addr, line_addr + 32'(4 * b));
         end
         mem_valid = 1'b1; mem_data = base + 32'(b);
         tick;
         mem_valid = 1'b0;
      end
      checks++;
      if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s after_last_beat: mem_req=%b resp_valid=%b required 0/0", name, mem_req, resp_valid);
      end
      tick;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp_word) begin
         errors++;
         $display("FAIL %s miss_resp: valid=%b data=%h required 1/%h", name, resp_valid, resp_data, exp_word);
      end
   endtask

   // Single-cycle hit: response on the next cycle, no memory traffic
   task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp_word, input string name);
      req_valid = 1'b1; req_addr = addr;
      tick;
      req_valid = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp_word || mem_req !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s hit: valid=%b data=%h mem_req=%b ready=%b required 1/%h/0/1",
                  name, resp_valid, resp_data, mem_req, req_ready, exp_word);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0 ||
          mem_req !== 1'b0 || mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: ready=%b rv=%b rd=%h mreq=%b maddr=%h required 1/0/0/0/0",
                  req_ready, resp_valid, resp_data, mem_req, mem_addr);
      end
   endtask

   task automatic test_cold_miss;
      do_miss(32'h0000_1004, 32'hA0, "cold");
      tick;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL cold_pulse_end: resp_valid=%b ready=%b required 0/1", resp_valid, req_ready);
      end
   endtask

   task automatic test_hit;
      do_hit(32'h0000_100C, 32'hA3, "hit_100c");
      do_hit(32'h0000_1000, 32'hA0, "hit_1000");
      tick;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL hit_pulse_end: resp_valid=%b required 0", resp_valid);
      end
   endtask

   task automatic test_lru;
      do_miss(32'h0000_2000, 32'hB0, "fill_2000");
      tick;
      do_hit(32'h0000_1000, 32'hA0, "touch_1000");
      do_miss(32'h0000_3008, 32'hC0, "fill_3000");
      tick;
      do_hit(32'h0000_1004, 32'hA1, "keep_1000");
      do_hit(32'h0000_3000, 32'hC0, "keep_3000");
      do_miss(32'h0000_2004, 32'hD0, "evicted_2000");
      tick;
   endtask

   task automatic test_ignore;
      req_valid = 1'b1; req_addr = 32'h0000_7040;
      tick;
      req_addr = 32'h0000_1000;
      tick;
      req_valid = 1'b0;
      checks++;
      if (mem_addr !== 32'h0000_7040 || resp_valid !== 1'b0 || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL ignore_req_in_refill: maddr=%h rv=%b mreq=%b required 00007040/0/1",
                  mem_addr, resp_valid, mem_req);
      end
      for (int b = 0; b < 4; b++) begin
         mem_valid = 1'b1; mem_data = 32'h70 + 32'(b);
         tick;
      end
      mem_valid = 1'b0;
      tick;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'h70) begin
         errors++;
         $display("FAIL ignore_resp: valid=%b data=%h required 1/00000070", resp_valid, resp_data);
      end
      mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
      tick; tick;
      mem_valid = 1'b0;
      checks++;
      if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL ignore_mem_in_idle: mreq=%b ready=%b rv=%b required 0/1/0", mem_req, req_ready, resp_valid);
      end
      do_hit(32'h0000_7044, 32'h71, "after_stray_beat");
      tick;
   endtask

   task automatic test_stall;
      req_valid = 1'b1; req_addr = 32'h0000_4018;
      tick;
      req_valid = 1'b0;
      mem_valid = 1'b1; mem_data = 32'hE0;
      tick;
      rdy = 1'b0; mem_data = 32'hEE;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if (mem_addr !== 32'h0000_4014 || mem_req !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: maddr=%h mreq=%b rv=%b ready=%b required 00004014/1/0/0",
                     i, mem_addr, mem_req, resp_valid, req_ready);
         end
      end
      rdy = 1'b1;
      for (int b = 1; b < 4; b++) begin
         checks++;
         if (mem_addr !== 32'h0000_4010 + 32'(4 * b)) begin
            errors++;
            $display("FAIL stall_beat%0d_addr: got %h required %h", b, mem_addr, 32'h0000_4010 + 32'(4 * b));
         end
         mem_data = 32'hE0 + 32'(b);
         tick;
      end
      mem_valid = 1'b0;
      tick;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'hE2) begin
         errors++;
         $display("FAIL stall_resp: valid=%b data=%h required 1/000000e2", resp_valid, resp_data);
      end
      tick;
   endtask

   task automatic test_reset_mid_refill;
      req_valid = 1'b1; req_addr = 32'h0000_5020;
      tick;
      req_valid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mem_valid = 1'b1; mem_data = 32'h90 + 32'(b);
         tick;
      end
      mem_valid = 1'b0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      checks++;
      if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0 || mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_state: ready=%b mreq=%b rv=%b maddr=%h required 1/0/0/0",
                  req_ready, mem_req, resp_valid, mem_addr);
      end
      tick;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_no_resp: resp_valid=%b required 0", resp_valid);
      end
      do_miss(32'h0000_5020, 32'h50, "refetch_after_reset");
      tick;
   endtask

   task automatic test_back_to_back;
      req_valid = 1'b1; req_addr = 32'h0000_5024;
      tick;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'h51) begin
         errors++;
         $display("FAIL b2b_first: valid=%b data=%h required 1/00000051", resp_valid, resp_data);
      end
      req_addr = 32'h0000_502C;
      tick;
      req_valid = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'h53) begin
         errors++;
         $display("FAIL b2b_second: valid=%b data=%h required 1/00000053", resp_valid, resp_data);
      end
      tick;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: resp_valid=%b required 0", resp_valid);
      end
   endtask

`ifdef ICACHE_FLUSH_EN
   task automatic test_flush;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_idle: rv=%b ready=%b required 0/1", resp_valid, req_ready);
      end
      do_miss(32'h0000_5024, 32'h60, "after_flush");
      tick;
      req_valid = 1'b1; req_addr = 32'h0000_6000;
      tick;
      req_valid = 1'b0;
      mem_valid = 1'b1; mem_data = 32'h61;
      tick;
      mem_valid = 1'b0;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL flush_refill: ready=%b rv=%b mreq=%b required 1/0/0", req_ready, resp_valid, mem_req);
      end
      tick;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_refill_no_resp: resp_valid=%b required 0", resp_valid);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_cold_miss;
      test_hit;
      test_lru;
      test_ignore;
      test_stall;
      test_reset_mid_refill;
      test_back_to_back;
`ifdef ICACHE_FLUSH_EN
      test_flush;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
